// File: rtl/seven_seg_capture_if.sv
// ============================================================================
// Module : seven_seg_capture_if
// Brief  : Digit-enable/segment sample lines and captured-frame outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seven_seg_capture_if;
  logic        dFourEn;
  logic        dThreeEn;
  logic        dTwoEn;
  logic        dOneEn;
  logic        CA;
  logic        CB;
  logic        CC;
  logic        CD;
  logic        CE;
  logic        CF;
  logic        CG;
  logic [15:0] bcdOut;
  logic [3:0]  digitValid;
  logic        frameDone;
  logic        segError;

  // master drives the display lines and observes the captured frame
  modport master (
    output dFourEn, dThreeEn, dTwoEn, dOneEn,
    output CA, CB, CC, CD, CE, CF, CG,
    input  bcdOut, digitValid, frameDone, segError
  );

  modport slave (
    input  dFourEn, dThreeEn, dTwoEn, dOneEn,
    input  CA, CB, CC, CD, CE, CF, CG,
    output bcdOut, digitValid, frameDone, segError
  );
endinterface

`default_nettype wire

// File: rtl/seven_seg_capture.sv
// ============================================================================
// Module : seven_seg_capture
// Brief  : Samples a multiplexed 7-segment display and rebuilds the 4-digit BCD.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_capture #(
  parameter int ACTIVE_LOW    = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  seven_seg_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLING = 2'd1,
    S_HELD     = 2'd2
  } state_t;

  localparam logic [7:0]  c_settle  = 8'(SETTLE_CYCLES);
  // Synchronizer resets to the wire idle level so no phantom enables appear.
  localparam logic [10:0] c_idleRaw = (ACTIVE_LOW != 0) ? 11'h7FF : 11'h000;

  logic [10:0] w_raw;
  logic [10:0] w_norm;
  logic [3:0]  w_en;
  logic [6:0]  w_seg;
  logic        w_none;
  logic        w_oneHot;
  logic        w_multi;
  logic        w_multiStart;
  logic        w_changed;
  logic [7:0]  w_cntInc;
  logic        w_capture;
  logic        w_frameComplete;
  logic [3:0]  w_decNib;
  logic        w_decOk;
  logic        w_decBad;
  state_t      w_nextState;
  logic [7:0]  w_nextCnt;

  logic [10:0] r_sync1;
  logic [10:0] r_sync2;
  logic [3:0]  r_prevEn;
  logic [6:0]  r_prevSeg;
  logic        r_prevMulti;
  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [15:0] r_shadowNib;
  logic [3:0]  r_shadowValid;
  logic [3:0]  r_mask;
  logic [15:0] r_bcdOut;
  logic [3:0]  r_digitValid;
  logic        r_frameDone;
  logic        r_segError;

  assign w_raw = {bus.dFourEn, bus.dThreeEn, bus.dTwoEn, bus.dOneEn,
                  bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1 <= c_idleRaw;
      r_sync2 <= c_idleRaw;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_norm = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_en   = w_norm[10:7];
  assign w_seg  = w_norm[6:0];

  assign w_none       = (w_en == 4'b0000);
  assign w_oneHot     = !w_none && ((w_en & (w_en - 4'd1)) == 4'b0000);
  assign w_multi      = !w_none && !w_oneHot;
  assign w_multiStart = w_multi && !r_prevMulti;
  assign w_changed    = (w_en != r_prevEn) || (w_seg != r_prevSeg);
  assign w_cntInc     = r_cnt + 8'd1;

  always_comb begin
    w_decNib = 4'hF;
    w_decOk  = 1'b0;
    w_decBad = 1'b0;
    case (w_seg)
      7'h7E: begin w_decNib = 4'd0; w_decOk = 1'b1; end
      7'h30: begin w_decNib = 4'd1; w_decOk = 1'b1; end
      7'h6D: begin w_decNib = 4'd2; w_decOk = 1'b1; end
      7'h79: begin w_decNib = 4'd3; w_decOk = 1'b1; end
      7'h33: begin w_decNib = 4'd4; w_decOk = 1'b1; end
      7'h5B: begin w_decNib = 4'd5; w_decOk = 1'b1; end
      7'h5F: begin w_decNib = 4'd6; w_decOk = 1'b1; end
      7'h70: begin w_decNib = 4'd7; w_decOk = 1'b1; end
      7'h7F: begin w_decNib = 4'd8; w_decOk = 1'b1; end
      7'h7B: begin w_decNib = 4'd9; w_decOk = 1'b1; end
      7'h00: begin w_decNib = 4'hF; w_decOk = 1'b0; end
      default: w_decBad = 1'b1;
    endcase
  end

  // Capture fires on the edge where the dwell count reaches SETTLE_CYCLES.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_capture   = 1'b0;
    if (!w_oneHot) begin
      w_nextState = S_IDLE;
      w_nextCnt   = 8'd0;
    end else if ((r_state == S_IDLE) || w_changed) begin
      w_nextCnt = 8'd1;
      if (c_settle == 8'd1) begin
        w_capture   = 1'b1;
        w_nextState = S_HELD;
      end else begin
        w_nextState = S_SETTLING;
      end
    end else if (r_state == S_SETTLING) begin
      w_nextCnt = w_cntInc;
      if (w_cntInc == c_settle) begin
        w_capture   = 1'b1;
        w_nextState = S_HELD;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_prevEn    <= 4'b0000;
      r_prevSeg   <= 7'h00;
      r_prevMulti <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_cnt       <= w_nextCnt;
      r_prevEn    <= w_en;
      r_prevSeg   <= w_seg;
      r_prevMulti <= w_multi;
    end
  end

  assign w_frameComplete = (r_mask == 4'b1111);

  // A capture coinciding with frame completion lands after the mask clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_shadowNib   <= 16'h0000;
      r_shadowValid <= 4'b0000;
      r_mask        <= 4'b0000;
      r_bcdOut      <= 16'h0000;
      r_digitValid  <= 4'b0000;
      r_frameDone   <= 1'b0;
      r_segError    <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_capture && w_en[i]) begin
          if (!w_decBad) begin
            r_shadowNib[i*4 +: 4] <= w_decNib;
          end
          r_shadowValid[i] <= w_decOk;
        end
      end
      r_mask      <= (w_frameComplete ? 4'b0000 : r_mask) | (w_capture ? w_en : 4'b0000);
      r_frameDone <= w_frameComplete;
      r_segError  <= w_multiStart || (w_capture && w_decBad);
      if (w_frameComplete) begin
        r_bcdOut     <= r_shadowNib;
        r_digitValid <= r_shadowValid;
      end
    end
  end

  assign bus.bcdOut     = r_bcdOut;
  assign bus.digitValid = r_digitValid;
  assign bus.frameDone  = r_frameDone;
  assign bus.segError   = r_segError;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_capture.sv
// ============================================================================
// Module : tb_seven_seg_capture
// Brief  : Scoreboard bench for seven_seg_capture with directed display scans.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_capture;

  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  valid;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  seven_seg_capture_if bus ();

  seven_seg_capture #(
    .ACTIVE_LOW   (1),
    .SETTLE_CYCLES(4)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  exp_t expQ[$];
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   frameCount = 0;
  int   errCount = 0;
  int   lastFrameCycle = 0;
  int   lastDriveCycle = 0;
  logic prevFrameDone = 1'b0;

  always @(posedge Clk) cycle <= cycle + 1;

  // Monitor: pops the expected frame whenever the DUT publishes one.
  always @(negedge Clk) begin
    if (Reset) begin
      prevFrameDone = 1'b0;
    end else begin
      if (bus.segError) errCount++;
      if (bus.frameDone) begin
        frameCount++;
        lastFrameCycle = cycle;
        tests++;
        if (prevFrameDone) begin
          fails++;
          $display("FAIL frame_back_to_back: frameDone high on consecutive cycles at cycle %0d", cycle);
        end
        tests++;
        if (expQ.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: got bcdOut=%h digitValid=%b, no frame expected", bus.bcdOut, bus.digitValid);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          tests++;
          if (bus.bcdOut !== e.bcd) begin
            fails++;
            $display("FAIL frame_bcd: got %h expected %h", bus.bcdOut, e.bcd);
          end
          tests++;
          if (bus.digitValid !== e.valid) begin
            fails++;
            $display("FAIL frame_valid: got %b expected %b", bus.digitValid, e.valid);
          end
        end
      end
      prevFrameDone = bus.frameDone;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h7E;
      1: return 7'h30;
      2: return 7'h6D;
      3: return 7'h79;
      4: return 7'h33;
      5: return 7'h5B;
      6: return 7'h5F;
      7: return 7'h70;
      8: return 7'h7F;
      9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic setWires(input logic [3:0] enN, input logic [6:0] segN);
    {bus.dFourEn, bus.dThreeEn, bus.dTwoEn, bus.dOneEn} = enN;
    {bus.CA, bus.CB, bus.CC, bus.CD, bus.CE, bus.CF, bus.CG} = segN;
  endtask

  task automatic idle(input int n);
    setWires(4'hF, 7'h7F);
    tick(n);
  endtask

  // idx 3 is digit 4 (most significant), seg is active-high {a..g}
  task automatic showDigit(input int idx, input logic [6:0] seg, input int dwell);
    logic [3:0] oh;
    oh = 4'b0001;
    oh = oh << idx;
    setWires(~oh, ~seg);
    lastDriveCycle = cycle;
    tick(dwell);
  endtask

  task automatic scan(input int d4, input int d3, input int d2, input int d1);
    showDigit(3, segOf(d4), 8);
    showDigit(2, segOf(d3), 8);
    showDigit(1, segOf(d2), 8);
    showDigit(0, segOf(d1), 8);
  endtask

  task automatic doReset(input int n);
    Reset = 1'b1;
    tick(n);
    Reset = 1'b0;
  endtask

  initial begin : stim
    int f0;
    int e0;
    Reset = 1'b1;
    setWires(4'hF, 7'h7F);
    tick(3);
    Reset = 1'b0;
    check("reset_bcd", 32'(bus.bcdOut), 32'h0000);
    check("reset_valid", 32'(bus.digitValid), 32'h0);
    check("reset_frameDone", 32'(bus.frameDone), 32'h0);
    check("reset_segError", 32'(bus.segError), 32'h0);
    idle(100);
    check("idle_frames", 32'(frameCount), 32'd0);
    check("idle_errors", 32'(errCount), 32'd0);

    // Basic scan 1,2,3,4 plus last-digit latency
    f0 = frameCount; e0 = errCount;
    expQ.push_back('{bcd: 16'h1234, valid: 4'b1111});
    scan(1, 2, 3, 4);
    check("basic_latency", 32'(lastFrameCycle - lastDriveCycle), 32'd7);
    idle(10);
    check("basic_frames", 32'(frameCount - f0), 32'd1);
    check("basic_errors", 32'(errCount - e0), 32'd0);

    // Short dwell on digit 2: frame only completes during the following scan
    doReset(2);
    f0 = frameCount;
    expQ.push_back('{bcd: 16'h5678, valid: 4'b1111});
    showDigit(3, segOf(5), 8);
    showDigit(2, segOf(6), 8);
    showDigit(1, segOf(7), 3);
    showDigit(0, segOf(8), 8);
    idle(4);
    check("short_dwell_no_frame", 32'(frameCount - f0), 32'd0);
    scan(5, 6, 7, 8);
    idle(10);
    check("short_dwell_next_frame", 32'(frameCount - f0), 32'd1);

    // Blank on digit 4, undecodable pattern on digit 3
    doReset(2);
    f0 = frameCount; e0 = errCount;
    expQ.push_back('{bcd: 16'hF056, valid: 4'b0011});
    showDigit(3, 7'h00, 8);
    showDigit(2, 7'h01, 8);
    showDigit(1, segOf(5), 8);
    showDigit(0, segOf(6), 8);
    idle(10);
    check("bad_seg_errors", 32'(errCount - e0), 32'd1);
    check("bad_seg_frames", 32'(frameCount - f0), 32'd1);

    // Two enables at once: one error pulse, outputs untouched
    f0 = frameCount; e0 = errCount;
    setWires(4'b1100, ~segOf(8));
    tick(6);
    idle(10);
    check("multi_en_errors", 32'(errCount - e0), 32'd1);
    check("multi_en_frames", 32'(frameCount - f0), 32'd0);
    check("multi_en_bcd_hold", 32'(bus.bcdOut), 32'hF056);
    check("multi_en_valid_hold", 32'(bus.digitValid), 32'b0011);

    // Reset mid-frame discards captured digits
    f0 = frameCount;
    showDigit(3, segOf(1), 8);
    showDigit(2, segOf(2), 8);
    idle(2);
    doReset(2);
    idle(4);
    check("midframe_reset_bcd", 32'(bus.bcdOut), 32'h0000);
    check("midframe_reset_valid", 32'(bus.digitValid), 32'h0);
    expQ.push_back('{bcd: 16'h9876, valid: 4'b1111});
    showDigit(3, segOf(9), 8);
    showDigit(2, segOf(8), 8);
    showDigit(1, segOf(7), 8);
    check("midframe_reset_partial", 32'(frameCount - f0), 32'd0);
    showDigit(0, segOf(6), 8);
    idle(10);
    check("midframe_reset_frames", 32'(frameCount - f0), 32'd1);

    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver: samples the four digit enables and seven cathode lines, and reconstructs the displayed 4-digit BCD value.
- Used in loopback and self-check builds. It sits beside the display driver on the same Clk and feeds the captured value back to the adder/decrementer control or to a bench monitor.
- Publishes a complete 16-bit BCD word once all four digits have been seen stable within one scan.

Parameters:
- ACTIVE_LOW, 1: when 1, the enable and segment inputs are active-low and are inverted internally; when 0, they are active-high.
- SETTLE_CYCLES, 4: number of consecutive Clk cycles an enable/segment pattern must hold before it is captured. Legal range is 1 to 255.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- dFourEn  input  1  digit-4 enable (most significant digit).
- dThreeEn  input  1  digit-3 enable.
- dTwoEn  input  1  digit-2 enable.
- dOneEn  input  1  digit-1 enable (least significant digit).
- CA, CB, CC, CD, CE, CF, CG  input  1 each  segment lines a to g.
- bcdOut  output  16  captured value: [15:12] is digit 4, [3:0] is digit 1.
- digitValid  output  4  per-digit decode-OK flags, same bit order as bcdOut nibbles.
- frameDone  output  1  one-cycle pulse when bcdOut and digitValid update.
- segError  output  1  one-cycle pulse on an undecodable segment pattern or on more than one enable active.

Behaviour:
- Reset (one Clk edge with Reset=1): bcdOut=16'h0000, digitValid=4'b0000, frameDone=0, segError=0.
  - Synchronizer flops, shadow registers, captured mask, settle counter and the captured flag are all cleared.
  - A reset mid-dwell or mid-frame discards all partial data. The first frameDone after reset requires a full fresh scan.
- Input path: all 11 inputs pass through a 2-flop synchronizer, then are normalised to active-high (inverted when ACTIVE_LOW=1).
  - The normalised segment vector is seg[6:0] = {a,b,c,d,e,f,g}.
- Enable qualification on the normalised enables:
  - Exactly one enable high: that digit is the active digit.
  - No enable high: idle. The settle counter clears.
  - Two or more high: segError pulses on the first cycle of that condition. The settle counter clears and nothing is captured.
- Settle FSM, states IDLE, SETTLING, HELD:
  - IDLE to SETTLING: a one-hot enable appears. Counter is loaded with 1.
  - SETTLING: counter increments each cycle while the enables and seg are unchanged from the previous cycle. Any change restarts SETTLING with counter=1 (or goes to IDLE if the enables become invalid).
  - SETTLING to HELD: when the counter reaches SETTLE_CYCLES, the digit is captured in that same cycle.
  - HELD: no re-capture while the pattern stays unchanged. Any change goes to SETTLING or IDLE.
- Decode, with seg shown as hex of {a..g}:
  - 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9.
  - 00 = blank: shadow nibble F, valid bit 0, no error.
  - Any other pattern: segError pulses for 1 cycle, shadow nibble is left unchanged, valid bit 0.
  - Every capture, including blank and error, sets that digit's bit in the captured mask.
- Frame completion:
  - When the captured mask becomes 4'b1111, the next cycle copies the shadow nibbles to bcdOut and the shadow valid bits to digitValid, pulses frameDone, and clears the mask.
  - A digit captured again before the frame completes overwrites its shadow nibble. The last capture wins.
- Simultaneous events: a capture in the same cycle as frame completion belongs to the next frame. Its mask bit is set after the clear.
- Latency: for the final digit of a frame, frameDone asserts 2 (sync) + SETTLE_CYCLES + 1 cycles after the digit's pattern first appears at the ports.
- bcdOut and digitValid hold their value between frameDone pulses. frameDone never asserts on consecutive cycles.

Test Plan:
- Reset with all inputs at 1 (active-low idle) -> bcdOut=0000, digitValid=0000, no frameDone; hold 100 cycles -> still no frameDone or segError.
- Scan 1,2,3,4 on digits 4 to 1 (segs 30, 6D, 79, 33; active-low on the wires), dwell 8 cycles each -> exactly one frameDone; bcdOut=16'h1234, digitValid=1111; frameDone 7 cycles after digit 1's pattern first appears (SETTLE_CYCLES=4).
- Dwell of 3 cycles (less than SETTLE_CYCLES) on digit 2 within an otherwise valid scan -> no capture and no frameDone that frame; next full-dwell scan -> frameDone with the correct value.
- Digit 3 driven with pattern 0x01 -> segError pulses for 1 cycle; at frame end digitValid[2]=0, other valid bits 1. Digit 4 blank (seg 00) -> nibble F, digitValid[3]=0, no segError.
- dOneEn and dTwoEn asserted together for 6 cycles -> a single segError pulse; no capture and no change to bcdOut.
- Assert Reset after digits 4 and 3 are captured, then scan 9,8,7,6 -> frameDone only after all four new digits; bcdOut=16'h9876, with no remnant of the pre-reset digits.
